// File: rtl/alu_acc_seq.sv
// alu_acc_seq: accumulator/sequencer that iterates an external combinational ALU over a command.
module alu_acc_seq #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_b,
    input  logic          cmd_load,
    input  logic [CW-1:0] cmd_rep,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_sel,
    input  logic          alu_c,
    input  logic [N-1:0]  alu_o,
    output logic [N-1:0]  acc,
    output logic          carry,
    output logic          zero,
    output logic          done
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
    logic [1:0]    state;
    logic [2:0]    op_reg;
    logic [N-1:0]  b_reg;
    logic [CW-1:0] cnt;
    assign cmd_ready = state == IDLE;
    assign done      = state == DONE;
    assign alu_a     = acc;
    assign alu_b     = b_reg;
    assign alu_sel   = op_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
            op_reg <= 3'b000;
            b_reg  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    if (cmd_load) begin
                        acc   <= cmd_b;
                        carry <= 1'b0;
                        zero  <= cmd_b == '0;
                        state <= DONE;
                    end else begin
                        op_reg <= cmd_op;
                        b_reg  <= cmd_b;
                        cnt    <= cmd_rep;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // flags track only the latest iteration
                    acc   <= alu_o;
                    carry <= alu_c;
                    zero  <= alu_o == '0;
                    if (cnt == '0) state <= DONE;
                    else cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
